// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// ID-stage hazard and sequencing controller for the 5-stage pipeline.
//   * Picks forwarding sources for the rs/rt operands from EX and MEM.
//   * Detects load-use hazards against the load currently in EX.
//   * Sequences the multi-cycle multiply/divide unit (IDLE/BUSY + down-counter).
//     It holds MD and HI/LO instructions in ID while that unit is busy.
//   * Stalls the front end (wpcir=0, bubble=1) and counts the stall cycles.
//
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt             source register numbers in ID
//   id_use_rs, id_use_rt     ID instruction really reads rs / rt
//   id_is_md, id_is_hilo     ID holds mult/div, or mfhi/mflo/mthi/mtlo
//   ex_wreg, ex_m2reg, ex_rn     EX writes a reg / is a load / destination
//   mem_wreg, mem_m2reg, mem_rn  MEM writes a reg / is a load / destination
//   fwda, fwdb               operand select: 00 rf, 01 EX alu, 10 MEM alu,
//                            11 MEM load data
//   wpcir                    1 = PC and IF/ID advance, 0 = hold
//   bubble                   1 = NOP into EX this cycle
//   md_start                 one-cycle start strobe to the MD unit
//   md_busy, md_done         MD computing / last busy cycle
//   stall_cnt                saturating count of cycles with wpcir=0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,  // legal 2..255
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_md,
  input  logic             id_is_hilo,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [7:0] CNT_INIT = 8'(MD_CYCLES - 1);

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  md_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lu, ms, stall;

  // The youngest producer wins. A load in EX has no data yet, so it is never
  // a forwarding source; the load-use stall covers that case. $0 is never
  // forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       used,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic       m_m2reg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && (src != 5'd0)) begin
      if (e_wreg && !e_m2reg && (e_rn == src))      sel = FWD_EX_ALU;
      else if (m_wreg && !m_m2reg && (m_rn == src)) sel = FWD_MEM_ALU;
      else if (m_wreg && m_m2reg && (m_rn == src))  sel = FWD_MEM_LD;
    end
    return sel;
  endfunction

  assign fwda = fwd_sel(id_rs, id_use_rs, ex_wreg, ex_m2reg, ex_rn,
                        mem_wreg, mem_m2reg, mem_rn);
  assign fwdb = fwd_sel(id_rt, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
                        mem_wreg, mem_m2reg, mem_rn);

  // The FSM outputs depend on state only. That breaks the path
  // md_busy -> ms -> stall -> md_start -> next state, so there is no
  // combinational loop.
  assign md_busy = (state_q == BUSY);
  assign md_done = (state_q == BUSY) && (cnt_q == 8'd0);

  assign lu = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rn)) ||
               (id_use_rt && (id_rt == ex_rn)));
  assign ms       = md_busy && (id_is_md || id_is_hilo);
  assign stall    = lu || ms;
  assign wpcir    = !stall;
  assign bubble   = stall;
  assign md_start = id_is_md && !stall;

  // NOTE: every variable gets its default before the case statement. A path
  // that left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the ID stage of the 5-stage pipeline. It decides forwarding selects for the two register-file read operands and detects load-use hazards. It also owns the multi-cycle multiply/divide (MD) unit's busy sequencing. From these it drives the PC/IF-ID write enable and the EX bubble insert that stall the front end. It sits beside the ID stage's register file and control unit, and takes destination info back from EX and MEM.

## Interface
Parameters:
- MD_CYCLES, 32, cycles the MD unit is busy after issue (legal 2..255)
- CNT_W, 16, width of the stall performance counter

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt
- id_is_md  in  1  ID holds mult/multu/div/divu
- id_is_hilo  in  1  ID holds mfhi/mflo/mthi/mtlo
- ex_wreg, ex_m2reg  in  1 each  EX instruction writes a register / is a load
- ex_rn  in  5  EX destination register
- mem_wreg, mem_m2reg  in  1 each  MEM instruction writes a register / is a load
- mem_rn  in  5  MEM destination register
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX alu result, 10 MEM alu result, 11 MEM load data
- wpcir  out  1  1 = PC and IF/ID register advance; 0 = hold
- bubble  out  1  1 = EX receives a NOP this cycle
- md_start  out  1  one-cycle start strobe to the MD unit
- md_busy  out  1  MD unit is computing
- md_done  out  1  one-cycle pulse in the last busy cycle
- stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0

## Operation
- Forwarding, per operand X in {rs, rt}, combinational. Priority applies only when X != 0 and the operand is used; otherwise 00:
  - 01 if ex_wreg & ~ex_m2reg & ex_rn == X
  - else 10 if mem_wreg & ~mem_m2reg & mem_rn == X
  - else 11 if mem_wreg & mem_m2reg & mem_rn == X
  - else 00
- Register $0 is never forwarded.
- Load-use stall lu: ex_wreg & ex_m2reg & ex_rn != 0 & ((id_use_rs & id_rs == ex_rn) | (id_use_rt & id_rt == ex_rn)).
- MD stall ms: md_busy & (id_is_md | id_is_hilo).
- stall = lu | ms. Outputs wpcir = ~stall and bubble = stall.
- md_start = id_is_md & ~stall, combinational.
- MD FSM has two states, IDLE and BUSY, plus an 8-bit down-counter cnt.
  - IDLE: when md_start, go to BUSY and set cnt = MD_CYCLES-1.
  - BUSY: md_busy = 1. If cnt != 0, decrement cnt. If cnt == 0, assert md_done and go to IDLE.
  - An md_start cannot occur in BUSY, because ms blocks it.
- stall_cnt increments on every clock where stall = 1 and saturates at all-ones.

## Timing
- Forwarding, wpcir, bubble and md_start are combinational from current inputs and state, with zero latency.
- When MD issues in cycle t: md_busy is high in t+1..t+MD_CYCLES, md_done is high in t+MD_CYCLES, and md_busy = 0 at t+MD_CYCLES+1. An mfhi in ID from t+1 onward advances at t+MD_CYCLES+1.
- Load-use stall lasts exactly one cycle. The load moves to MEM and its data is then forwarded via 11.
- When lu and ms are both set, there is one stall. stall_cnt adds 1 per cycle.
- Reset, asynchronous and at any time including mid-MD: state IDLE, cnt 0, md_busy 0, md_done 0, stall_cnt 0.
  - With all inputs 0 after reset: fwda = fwdb = 00, wpcir = 1, bubble = 0, md_start = 0.
  - An MD operation in progress when reset hits is abandoned, with no md_done.

## Test plan
- EX add writes $8, ID reads rs = $8 (use_rs = 1), MEM also writes $8 -> fwda = 01. Same case with ex_wreg = 0 -> fwda = 10. MEM is a load to $8 -> fwda = 11. rs = $0 with all matching -> fwda = 00.
- EX lw to $9, ID rt = $9 with use_rt = 1 -> wpcir = 0, bubble = 1 for one cycle, stall_cnt = 1. Same with use_rt = 0 -> no stall.
- MD_CYCLES = 4: mult issued at cycle 0, mfhi in ID from cycle 1 -> md_busy high in cycles 1-4, md_done in cycle 4, wpcir = 0 in cycles 1-4, wpcir = 1 at cycle 5, stall_cnt = 4.
- Back-to-back: div is in ID while BUSY -> md_start = 0 until the cycle after md_done, then one md_start pulse.
- resetn low in cycle 2 of a 4-cycle MD -> md_busy = 0 immediately, no md_done, stall_cnt = 0. After release with inputs zero -> wpcir = 1.
- CNT_W = 4 with 20 forced stall cycles -> stall_cnt saturates at 15.
